// File: rtl/mt9v032_serializer.sv
// -----------------------------------------------------------------------------
// mt9v032_serializer
//
// Transmit side of the MT9V032 LVDS serial pixel link. Takes a parallel pixel
// stream qualified by line/frame valid and emits one 12-bit framed word every
// 12 clocks, one bit per clock:
//   bit 0      start (1)
//   bits 1..10 payload, LSB first
//   bit 11     stop (0)
// Line and frame boundaries are signalled in-band by a three-word sync
// sequence (0x3FF, 0x000, code) followed by the word that was displaced by
// the sync (the pixel or blank captured with the boundary sample).
//
// Parameters
//   TRAIN_WORD  payload sent every slot while train is high
//   CLAMP       non-zero: pixel values 0x000/0x3FF are sent as 0x001/0x3FE,
//               so that 0x3FF only ever appears as a sync preamble
//
// Ports
//   clk          bit clock
//   rst_n        synchronous active-low reset
//   train        send TRAIN_WORD instead of data; sampled at slot load
//   in_px        pixel value, sampled when px_req is high
//   in_lv        line valid, sampled when px_req is high
//   in_fv        frame valid, sampled when px_req is high
//   px_req       one-cycle request: source presents next pixel this cycle
//   out_bit      serial data
//   word_start   high during the start-bit cycle of every word
//   sync_active  high for all 12 bits of every sync-sequence word
//
// Handshake: px_req is a strict one-cycle request with no backpressure. The
// source must have in_px/in_lv/in_fv valid in the same cycle px_req is high;
// the serializer samples them at the following rising edge. There is no
// ready/valid return path -- the source simply obeys px_req.
// -----------------------------------------------------------------------------
module mt9v032_serializer #(
   parameter logic [9:0] TRAIN_WORD = 10'h0AA,
   parameter int unsigned CLAMP      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       train,
   input  logic [9:0] in_px,
   input  logic       in_lv,
   input  logic       in_fv,
   output logic       px_req,
   output logic       out_bit,
   output logic       word_start,
   output logic       sync_active
);

   localparam logic [3:0] LAST_BIT  = 4'd11;

   localparam logic [9:0] W_BLANK    = 10'h000;
   localparam logic [9:0] W_PREAMBLE = 10'h3FF;
   localparam logic [9:0] C_SOL      = 10'h001;
   localparam logic [9:0] C_SOF      = 10'h002;
   localparam logic [9:0] C_EOL      = 10'h004;
   localparam logic [9:0] C_EOF      = 10'h008;

   typedef enum logic [1:0] {
      ST_DATA  = 2'd0,
      ST_SYNC1 = 2'd1,
      ST_SYNC2 = 2'd2,
      ST_HELD  = 2'd3
   } state_e;

   // cnt_q is the index of the bit that the next rising edge will put on
   // out_bit. The edge with cnt_q == 0 emits the start bit and loads the
   // payload shift register, so the cycle before it (stop bit showing on
   // out_bit) is the load cycle in which the source is asked for a pixel.
   logic [3:0] cnt_q,       cnt_d;
   state_e     state_q,     state_d;
   logic [9:0] word_q,      word_d;     // payload shift register, LSB out first
   logic [9:0] held_q,      held_d;     // word displaced by a sync sequence
   logic [9:0] code_q,      code_d;     // sync code of the pending sequence
   logic       prev_lv_q,   prev_lv_d;
   logic       prev_fv_q,   prev_fv_d;
   logic       req_q,       req_d;      // load cycle that may accept a sample
   logic       out_bit_q,   out_bit_d;
   logic       wstart_q,    wstart_d;
   logic       sync_q,      sync_d;

   // Sample decode -------------------------------------------------------------
   logic       lv_e;
   logic [9:0] ev_code;
   logic [9:0] px_clamped;
   logic [9:0] sample_word;

   assign lv_e = in_lv & in_fv;

   // Frame edges win over line edges, so a combined edge yields one sequence.
   always_comb begin
      ev_code = W_BLANK;
      if (in_fv && !prev_fv_q) begin
         ev_code = C_SOF;
      end else if (!in_fv && prev_fv_q) begin
         ev_code = C_EOF;
      end else if (lv_e && !prev_lv_q) begin
         ev_code = C_SOL;
      end else if (!lv_e && prev_lv_q) begin
         ev_code = C_EOL;
      end
   end

   always_comb begin
      px_clamped = in_px;
      if (CLAMP != 0) begin
         if (in_px == 10'h000) begin
            px_clamped = 10'h001;
         end else if (in_px == 10'h3FF) begin
            px_clamped = 10'h3FE;
         end
      end
   end

   assign sample_word = lv_e ? px_clamped : W_BLANK;

   // Next-state logic ----------------------------------------------------------
   always_comb begin
      cnt_d     = (cnt_q == LAST_BIT) ? 4'd0 : cnt_q + 4'd1;
      state_d   = state_q;
      word_d    = word_q;
      held_d    = held_q;
      code_d    = code_q;
      prev_lv_d = prev_lv_q;
      prev_fv_d = prev_fv_q;
      sync_d    = sync_q;
      // Only a slot loaded in DATA may take a new sample from the source.
      req_d     = (cnt_q == LAST_BIT) && (state_q == ST_DATA);
      wstart_d  = (cnt_q == 4'd0);
      out_bit_d = 1'b0;

      case (cnt_q)
         4'd0: begin
            out_bit_d = 1'b1;
         end
         LAST_BIT: begin
            out_bit_d = 1'b0;
         end
         default: begin
            out_bit_d = word_q[0];
            word_d    = {1'b0, word_q[9:1]};
         end
      endcase

      // Word selection at the start-bit edge.
      if (cnt_q == 4'd0) begin
         if (train) begin
            // Training overrides everything and forgets the line/frame
            // history so that a running frame restarts with a fresh SOF.
            word_d    = TRAIN_WORD;
            sync_d    = 1'b0;
            state_d   = ST_DATA;
            prev_lv_d = 1'b0;
            prev_fv_d = 1'b0;
         end else begin
            case (state_q)
               ST_DATA: begin
                  sync_d = 1'b0;
                  if (req_q) begin
                     prev_fv_d = in_fv;
                     prev_lv_d = lv_e;
                     if (ev_code != W_BLANK) begin
                        word_d  = W_PREAMBLE;
                        sync_d  = 1'b1;
                        held_d  = sample_word;
                        code_d  = ev_code;
                        state_d = ST_SYNC1;
                     end else begin
                        word_d = sample_word;
                     end
                  end else begin
                     // First slot after reset: nobody was asked for data.
                     word_d = W_BLANK;
                  end
               end
               ST_SYNC1: begin
                  word_d  = W_BLANK;
                  sync_d  = 1'b1;
                  state_d = ST_SYNC2;
               end
               ST_SYNC2: begin
                  word_d  = code_q;
                  sync_d  = 1'b1;
                  state_d = ST_HELD;
               end
               ST_HELD: begin
                  word_d  = held_q;
                  sync_d  = 1'b0;
                  state_d = ST_DATA;
               end
               default: begin
                  word_d  = W_BLANK;
                  sync_d  = 1'b0;
                  state_d = ST_DATA;
               end
            endcase
         end
      end
   end

   // State registers -----------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= 4'd0;
         state_q   <= ST_DATA;
         word_q    <= W_BLANK;
         held_q    <= W_BLANK;
         code_q    <= W_BLANK;
         prev_lv_q <= 1'b0;
         prev_fv_q <= 1'b0;
         req_q     <= 1'b0;
         out_bit_q <= 1'b0;
         wstart_q  <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         word_q    <= word_d;
         held_q    <= held_d;
         code_q    <= code_d;
         prev_lv_q <= prev_lv_d;
         prev_fv_q <= prev_fv_d;
         req_q     <= req_d;
         out_bit_q <= out_bit_d;
         wstart_q  <= wstart_d;
         sync_q    <= sync_d;
      end
   end

   // Outputs -------------------------------------------------------------------
   // A train request in the load cycle suppresses the pixel request at once.
   assign px_req      = req_q & ~train;
   assign out_bit     = out_bit_q;
   assign word_start  = wstart_q;
   assign sync_active = sync_q;

endmodule

// File: tb/tb_mt9v032_serializer.sv
module tb_mt9v032_serializer;

   localparam logic [9:0] TRAIN_WORD = 10'h0AA;

   // Clock / reset -------------------------------------------------------------
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       train = 1'b0;
   logic [9:0] in_px = 10'h000;
   logic       in_lv = 1'b0;
   logic       in_fv = 1'b0;
   logic       px_req;
   logic       out_bit;
   logic       word_start;
   logic       sync_active;

   always #5 clk = ~clk;

   mt9v032_serializer #(
      .TRAIN_WORD (TRAIN_WORD),
      .CLAMP      (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .train       (train),
      .in_px       (in_px),
      .in_lv       (in_lv),
      .in_fv       (in_fv),
      .px_req      (px_req),
      .out_bit     (out_bit),
      .word_start  (word_start),
      .sync_active (sync_active)
   );

   // Scoreboard state ----------------------------------------------------------
   int checks = 0;
   int errors = 0;

   logic [10:0] exp_q[$];     // {sync_active, payload} per expected word
   logic [10:0] pend_q[$];    // words still owed by a started sync sequence
   bit          m_fv = 1'b0;  // reference model of the previous accepted sample
   bit          m_lv = 1'b0;
   int          exp_req_cnt  = 0;
   int          seen_req_cnt = 0;
   bit          done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [9:0] clamp_px(input logic [9:0] v);
      if (v == 10'h000) return 10'h001;
      if (v == 10'h3FF) return 10'h3FE;
      return v;
   endfunction

   // Driver tasks --------------------------------------------------------------
   // Called at the falling edge of a load cycle (stop bit on out_bit). Drives
   // this slot's inputs, predicts the resulting word and advances one slot.
   task automatic load_slot(input bit tr, input bit fv, input bit lv, input logic [9:0] px);
      bit         exp_req;
      bit         lve;
      logic [9:0] code;
      logic [9:0] pix;
      train = tr;
      in_fv = fv;
      in_lv = lv;
      in_px = px;
      #1;
      exp_req = !tr && (pend_q.size() == 0);
      check("px_req at load", px_req, exp_req);
      if (exp_req) exp_req_cnt++;
      if (tr) begin
         exp_q.push_back({1'b0, TRAIN_WORD});
         pend_q.delete();
         m_fv = 1'b0;
         m_lv = 1'b0;
      end else if (pend_q.size() != 0) begin
         exp_q.push_back(pend_q.pop_front());
      end else begin
         lve  = lv & fv;
         pix  = lve ? clamp_px(px) : 10'h000;
         code = 10'h000;
         if (fv != m_fv)       code = fv  ? 10'h002 : 10'h008;
         else if (lve != m_lv) code = lve ? 10'h001 : 10'h004;
         m_fv = fv;
         m_lv = lve;
         if (code != 10'h000) begin
            exp_q.push_back({1'b1, 10'h3FF});
            pend_q.push_back({1'b1, 10'h000});
            pend_q.push_back({1'b1, code});
            pend_q.push_back({1'b0, pix});
         end else begin
            exp_q.push_back({1'b0, pix});
         end
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic sync_slots();
      repeat (3) load_slot(1'b0, in_fv, in_lv, in_px);
   endtask

   // Releases reset at a falling edge and returns at the first load cycle.
   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      m_fv  = 1'b0;
      m_lv  = 1'b0;
      pend_q.delete();
      exp_q.push_back({1'b0, 10'h000});
      @(negedge clk);
      #1;
      check("first start after reset word_start", word_start, 1);
      check("first start after reset out_bit", out_bit, 1);
      repeat (11) @(negedge clk);
   endtask

   // Monitor -------------------------------------------------------------------
   logic [11:0] mon_bits  = '0;
   int          mon_idx   = 0;
   int          mon_sync  = 0;
   bit          mon_coll  = 1'b0;
   bit          mon_nexts = 1'b0;
   logic [10:0] mon_e;

   always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         mon_coll  = 1'b0;
         mon_nexts = 1'b0;
      end else begin
         if (px_req && !done) seen_req_cnt++;
         if (mon_coll) begin
            check("word_start inside word", word_start, 0);
            mon_bits[mon_idx] = out_bit;
            mon_sync += int'(sync_active);
            mon_idx++;
            if (mon_idx == 12) begin
               mon_coll  = 1'b0;
               mon_nexts = 1'b1;
               check("start bit", mon_bits[0], 1);
               check("stop bit", mon_bits[11], 0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected word: got %0h expected none", mon_bits[10:1]);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("word payload", mon_bits[10:1], mon_e[9:0]);
                  check("sync_active bit count", mon_sync, mon_e[10] ? 12 : 0);
               end
            end
         end else if (!done) begin
            if (word_start) begin
               mon_coll    = 1'b1;
               mon_bits[0] = out_bit;
               mon_idx     = 1;
               mon_sync    = int'(sync_active);
               mon_nexts   = 1'b0;
            end else if (mon_nexts) begin
               check("word_start after stop", word_start, 1);
               mon_nexts = 1'b0;
            end
         end
      end
   end

   // Stimulus ------------------------------------------------------------------
   initial begin
      bit         r_fv;
      bit         r_lv;
      bit         r_tr;
      logic [9:0] r_px;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset out_bit", out_bit, 0);
      check("reset px_req", px_req, 0);
      check("reset word_start", word_start, 0);
      check("reset sync_active", sync_active, 0);

      release_reset();

      // Idle blanking, then training.
      repeat (3) load_slot(1'b0, 1'b0, 1'b0, 10'($urandom));
      repeat (3) load_slot(1'b1, 1'b0, 1'b0, 10'($urandom));

      // Frame and line start together, then line end.
      load_slot(1'b0, 1'b1, 1'b1, 10'h155);
      sync_slots();
      load_slot(1'b0, 1'b1, 1'b0, 10'h2A2);
      sync_slots();

      // Four-pixel line exercising the clamp, then line end.
      load_slot(1'b0, 1'b1, 1'b1, 10'h000);
      sync_slots();
      load_slot(1'b0, 1'b1, 1'b1, 10'h3FF);
      load_slot(1'b0, 1'b1, 1'b1, 10'h010);
      load_slot(1'b0, 1'b1, 1'b1, 10'h200);
      load_slot(1'b0, 1'b1, 1'b0, 10'h155);
      sync_slots();

      // Line open, then frame and line fall together, then lv with fv low.
      load_slot(1'b0, 1'b1, 1'b1, 10'h123);
      sync_slots();
      load_slot(1'b0, 1'b0, 1'b0, 10'h321);
      sync_slots();
      load_slot(1'b0, 1'b0, 1'b1, 10'h0F0);
      load_slot(1'b0, 1'b0, 1'b1, 10'h0F1);
      load_slot(1'b0, 1'b0, 1'b0, 10'h0F2);

      // Training aborts a pending sync sequence; the frame restarts with SOF.
      load_slot(1'b0, 1'b1, 1'b1, 10'h0AB);
      load_slot(1'b1, 1'b1, 1'b1, 10'h0AB);
      load_slot(1'b0, 1'b1, 1'b1, 10'h0CD);
      sync_slots();

      // Reset in the middle of the code word of a sync sequence.
      load_slot(1'b0, 1'b0, 1'b0, 10'h000);
      sync_slots();
      load_slot(1'b0, 1'b1, 1'b0, 10'h111);
      load_slot(1'b0, 1'b1, 1'b0, 10'h111);
      #1;
      check("px_req in SYNC2 load", px_req, 0);
      repeat (5) @(negedge clk);
      #1;
      check("sync_active before reset", sync_active, 1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("mid-word reset out_bit", out_bit, 0);
      check("mid-word reset sync_active", sync_active, 0);
      check("mid-word reset word_start", word_start, 0);
      exp_q.delete();
      pend_q.delete();
      @(negedge clk);
      release_reset();
      load_slot(1'b0, 1'b1, 1'b1, 10'h1C3);
      sync_slots();

      // Randomized traffic.
      r_fv = 1'b1;
      r_lv = 1'b1;
      for (int i = 0; i < 250; i++) begin
         r_tr = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 7) == 0) r_fv = ~r_fv;
         if ($urandom_range(0, 2) == 0) r_lv = ~r_lv;
         case ($urandom_range(0, 5))
            0:       r_px = 10'h000;
            1:       r_px = 10'h3FF;
            default: r_px = 10'($urandom);
         endcase
         load_slot(r_tr, r_fv, r_lv, r_px);
      end

      // Stop taking new words; the word in flight still completes.
      #1;
      done = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      check("expected queue drained", exp_q.size(), 0);
      check("px_req pulse count", seen_req_cnt, exp_req_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
